// File: rtl/tx_pkt_arbiter_pkg.sv
// Shared state encodings, bank count and bus width defaults for the
// USB TX packet arbiter.
`ifndef USB_ADDR_NBIT
`define USB_ADDR_NBIT 8
`endif
`ifndef USB_DATA_NBIT
`define USB_DATA_NBIT 16
`endif

package tx_pkt_arbiter_pkg;

    typedef enum logic [1:0] {
        TXARB_IDLE,
        TXARB_ARB,
        TXARB_XFER,
        TXARB_CLOSE
    } txarb_state_t;

    localparam int TXARB_NBANK = 2;

endpackage

// File: rtl/tx_pkt_arbiter_if.sv
// Write port of the ping-pong USB TX buffer plus the drain-done pulse
// returned by the slave-FIFO controller.
interface tx_pkt_arbiter_if #(
    parameter int AW = `USB_ADDR_NBIT,
    parameter int DW = `USB_DATA_NBIT
);
    logic          tx_vd;
    logic [AW:0]   tx_addr;
    logic [DW-1:0] tx_data;
    logic          tx_eop;
    logic [AW:0]   tx_len;
    logic          tx_done;

    modport master (
        output tx_vd, tx_addr, tx_data, tx_eop, tx_len,
        input  tx_done
    );

    modport slave (
        input  tx_vd, tx_addr, tx_data, tx_eop, tx_len,
        output tx_done
    );
endinterface

// File: rtl/tx_pkt_arbiter_rr_arbiter.sv
// Combinational circular-priority pick: first asserted request at or
// after ptr, returned as one-hot grant plus index.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = PW'(k);
            end
        end
    end
endmodule

// File: rtl/tx_pkt_arbiter.sv
// Round-robin owner of the 2-bank USB TX buffer write port.
// Optional TXARB_TIMEOUT_EN adds a stall watchdog that forces CLOSE.
module tx_pkt_arbiter
    import tx_pkt_arbiter_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int AW          = `USB_ADDR_NBIT,
    parameter int DW          = `USB_DATA_NBIT,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    in_vd,
    input  logic [NREQ*DW-1:0] in_data,
    input  logic [NREQ-1:0]    in_eop,
    output logic [NREQ-1:0]    in_rdy,
    output logic [NREQ-1:0]    gnt,
    output logic               ovf_err,
    tx_pkt_arbiter_if.master   tx
);
    localparam int PW = $clog2(NREQ);

    txarb_state_t  state;
    logic          bank;
    logic [1:0]    pend;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gidx;
    logic [AW:0]   cnt;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_any;
    logic            acc;
    logic            inc;
    logic            dec;
    logic            can_go;
    logic            close_ok;
    logic            to_hit;
    logic [PW-1:0]   nxt_ptr;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign in_rdy   = (state == TXARB_XFER) ? gnt : '0;
    assign acc      = |(in_rdy & in_vd);
    assign close_ok = (cnt != '0);
    assign inc      = (state == TXARB_CLOSE) && close_ok;
    assign dec      = tx.tx_done && (pend != 2'd0);
    // a drain in this cycle frees a bank, so IDLE need not wait for it
    assign can_go   = (pend < 2'(TXARB_NBANK)) || dec;
    assign nxt_ptr  = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);

`ifdef TXARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    assign to_hit = !acc && (32'(to_cnt) >= TIMEOUT_CYC - 1);

    always_ff @(posedge clk) begin
        if (rst || state != TXARB_XFER || acc)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end
`else
    assign to_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TXARB_IDLE;
            gnt        <= '0;
            gidx       <= '0;
            rr_ptr     <= '0;
            bank       <= 1'b0;
            pend       <= 2'd0;
            cnt        <= '0;
            ovf_err    <= 1'b0;
            tx.tx_vd   <= 1'b0;
            tx.tx_addr <= '0;
            tx.tx_data <= '0;
            tx.tx_eop  <= 1'b0;
            tx.tx_len  <= '0;
        end else begin
            tx.tx_vd  <= 1'b0;
            tx.tx_eop <= 1'b0;
            if (inc && !dec)
                pend <= pend + 2'd1;
            else if (dec && !inc)
                pend <= pend - 2'd1;
            unique case (state)
                TXARB_IDLE: begin
                    if (|req && can_go)
                        state <= TXARB_ARB;
                end
                TXARB_ARB: begin
                    if (arb_any) begin
                        gnt   <= arb_gnt;
                        gidx  <= arb_idx;
                        cnt   <= '0;
                        state <= TXARB_XFER;
                    end else begin
                        state <= TXARB_IDLE;
                    end
                end
                TXARB_XFER: begin
                    if (acc) begin
                        // once the bank is full, words are swallowed
                        if (!cnt[AW]) begin
                            tx.tx_vd   <= 1'b1;
                            tx.tx_addr <= {bank, cnt[AW-1:0]};
                            tx.tx_data <= in_data[gidx*DW +: DW];
                            cnt        <= cnt + 1'b1;
                        end else begin
                            ovf_err <= 1'b1;
                        end
                        if (in_eop[gidx])
                            state <= TXARB_CLOSE;
                    end else if (to_hit) begin
                        state <= TXARB_CLOSE;
                    end
                end
                TXARB_CLOSE: begin
                    if (close_ok) begin
                        tx.tx_eop <= 1'b1;
                        tx.tx_len <= cnt;
                        bank      <= ~bank;
                    end
                    rr_ptr <= nxt_ptr;
                    gnt    <= '0;
                    state  <= TXARB_IDLE;
                end
                default: state <= TXARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Directed self-checking bench for tx_pkt_arbiter (NREQ=3, AW=8, DW=16).
// Define TXARB_TIMEOUT_EN for the watchdog cases.
module tb_tx_pkt_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 8;
    localparam int DW   = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    in_vd = '0;
    logic [NREQ*DW-1:0] in_data = '0;
    logic [NREQ-1:0]    in_eop = '0;
    logic [NREQ-1:0]    in_rdy;
    logic [NREQ-1:0]    gnt;
    logic               ovf_err;

    tx_pkt_arbiter_if #(.AW(AW), .DW(DW)) tx ();

    tx_pkt_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYC(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .in_vd   (in_vd),
        .in_data (in_data),
        .in_eop  (in_eop),
        .in_rdy  (in_rdy),
        .gnt     (gnt),
        .ovf_err (ovf_err),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW:0]   wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            eop_q[$];
    int            last_wr_cyc = 0;
    int            eop_cyc = 0;

    always @(negedge clk) begin
        if (tx.tx_vd) begin
            wa_q.push_back(tx.tx_addr);
            wd_q.push_back(tx.tx_data);
            last_wr_cyc = cyc;
        end
        if (tx.tx_eop) begin
            eop_q.push_back(int'(tx.tx_len));
            eop_cyc = cyc;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        eop_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        in_vd = '0;
        in_eop = '0;
        tx.tx_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int r, input int nw, input int base,
                        input bit last_eop);
        int t;
        t = 0;
        while (!in_rdy[r] && t < 40) begin
            tick();
            t++;
        end
        if (!in_rdy[r]) begin
            check($sformatf("rdy_wait%0d", r), 32'(in_rdy), 32'(1 << r));
            return;
        end
        for (int i = 0; i < nw; i++) begin
            in_vd[r] = 1'b1;
            in_data[r*DW +: DW] = DW'(base + i);
            in_eop[r] = last_eop && (i == nw - 1);
            tick();
        end
        in_vd[r] = 1'b0;
        in_eop[r] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] seen;
        int r;
        int t;
        int expd;
        tx.tx_done = 1'b0;

        // reset state
        do_reset();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_in_rdy", 32'(in_rdy), 0);
        check("rst_tx_vd", 32'(tx.tx_vd), 0);
        check("rst_tx_addr", 32'(tx.tx_addr), 0);
        check("rst_tx_data", 32'(tx.tx_data), 0);
        check("rst_tx_eop", 32'(tx.tx_eop), 0);
        check("rst_tx_len", 32'(tx.tx_len), 0);
        check("rst_ovf", 32'(ovf_err), 0);

        // single packet on requester 1
        clear_log();
        req[1] = 1'b1;
        tick();
        check("t1_gnt_arb", 32'(gnt), 0);
        tick();
        check("t1_gnt", 32'(gnt), 32'h2);
        check("t1_rdy", 32'(in_rdy), 32'h2);
        send(1, 4, 'hA001, 1'b1);
        req[1] = 1'b0;
        check("t1_rdy_close", 32'(in_rdy), 0);
        tick();
        tick();
        check("t1_nwr", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wa_q.size()) begin
                check($sformatf("t1_addr%0d", i), 32'(wa_q[i]), i);
                check($sformatf("t1_data%0d", i), 32'(wd_q[i]), 'hA001 + i);
            end
        end
        check("t1_neop", eop_q.size(), 1);
        check("t1_len", 32'(tx.tx_len), 4);
        check("t1_eop_lag", eop_cyc - last_wr_cyc, 1);
        check("t1_bank", 32'(dut.bank), 1);
        check("t1_pend", 32'(dut.pend), 1);

        // round-robin with all requests held
        do_reset();
        clear_log();
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            r = k % 3;
            t = 0;
            while (gnt == '0 && t < 20) begin
                tick();
                t++;
            end
            check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << r));
            send(r, 2, 'h1000 * (r + 1) + 'h10 * k, 1'b1);
            tick();
            check($sformatf("rr_eop%0d", k), 32'(tx.tx_eop), 1);
            check($sformatf("rr_len%0d", k), 32'(tx.tx_len), 2);
            tx.tx_done = 1'b1;
            tick();
            tx.tx_done = 1'b0;
        end
        req = '0;
        check("rr_nwr", wa_q.size(), 8);
        for (int j = 0; j < 8; j++) begin
            if (j < wa_q.size()) begin
                expd = (((j / 2) % 2) << 8) | (j % 2);
                check($sformatf("rr_addr%0d", j), 32'(wa_q[j]), expd);
                expd = 'h1000 * ((j / 2) % 3 + 1) + 'h10 * (j / 2) + (j % 2);
                check($sformatf("rr_data%0d", j), 32'(wd_q[j]), expd);
            end
        end

        // backpressure: two banks outstanding
        do_reset();
        clear_log();
        req[0] = 1'b1;
        send(0, 2, 'h3000, 1'b1);
        req[0] = 1'b0;
        req[1] = 1'b1;
        send(1, 2, 'h3100, 1'b1);
        req[1] = 1'b0;
        tick();
        tick();
        check("bp_pend2", 32'(dut.pend), 2);
        check("bp_neop", eop_q.size(), 2);
        req[2] = 1'b1;
        seen = '0;
        repeat (10) begin
            tick();
            seen |= gnt;
        end
        check("bp_nognt", 32'(seen), 0);
        tx.tx_done = 1'b1;
        tick();
        tx.tx_done = 1'b0;
        check("bp_gnt_arb", 32'(gnt), 0);
        check("bp_pend1", 32'(dut.pend), 1);
        tick();
        check("bp_gnt", 32'(gnt), 32'h4);
        send(2, 2, 'h3200, 1'b1);
        req[2] = 1'b0;
        tx.tx_done = 1'b1;
        tick();
        tx.tx_done = 1'b0;
        check("bp_eop3", 32'(tx.tx_eop), 1);
        check("bp_pend_same", 32'(dut.pend), 1);
        if (wa_q.size() > 4)
            check("bp_addr3", 32'(wa_q[4]), 0);

        // overflow: 260 words into a 256-word bank
        do_reset();
        clear_log();
        req[0] = 1'b1;
        send(0, 260, 0, 1'b1);
        req[0] = 1'b0;
        tick();
        tick();
        check("ov_nwr", wa_q.size(), 256);
        if (wa_q.size() >= 256) begin
            check("ov_last_addr", 32'(wa_q[255]), 'h0FF);
            check("ov_last_data", 32'(wd_q[255]), 'h0FF);
        end
        check("ov_err", 32'(ovf_err), 1);
        check("ov_len", 32'(tx.tx_len), 'h100);
        check("ov_neop", eop_q.size(), 1);
        check("ov_eop_lag", eop_cyc - last_wr_cyc, 5);

        // reset in the middle of a packet
        clear_log();
        req[0] = 1'b1;
        send(0, 3, 'h5000, 1'b0);
        rst = 1'b1;
        tick();
        check("mr_gnt", 32'(gnt), 0);
        check("mr_rdy", 32'(in_rdy), 0);
        check("mr_tx_vd", 32'(tx.tx_vd), 0);
        check("mr_tx_addr", 32'(tx.tx_addr), 0);
        check("mr_tx_data", 32'(tx.tx_data), 0);
        check("mr_tx_eop", 32'(tx.tx_eop), 0);
        check("mr_tx_len", 32'(tx.tx_len), 0);
        check("mr_ovf", 32'(ovf_err), 0);
        rst = 1'b0;
        tick();
        check("mr_neop", eop_q.size(), 0);
        clear_log();
        send(0, 2, 'h5100, 1'b1);
        req[0] = 1'b0;
        tick();
        tick();
        if (wa_q.size() > 0)
            check("mr_addr0", 32'(wa_q[0]), 0);
        check("mr_len", 32'(tx.tx_len), 2);
        check("mr_neop2", eop_q.size(), 1);

`ifdef TXARB_TIMEOUT_EN
        // stalled requester: one word, then nothing
        do_reset();
        clear_log();
        req[2] = 1'b1;
        send(2, 1, 'h6000, 1'b0);
        t = 0;
        while (!tx.tx_eop && t < 40) begin
            tick();
            t++;
        end
        check("to_eop", 32'(tx.tx_eop), 1);
        check("to_len", 32'(tx.tx_len), 1);
        check("to_gnt_rel", 32'(gnt), 0);
        t = 0;
        while (gnt == '0 && t < 10) begin
            tick();
            t++;
        end
        check("to_regnt", 32'(gnt), 32'h4);
        t = 0;
        while (gnt != '0 && t < 40) begin
            tick();
            t++;
        end
        req[2] = 1'b0;
        check("to_empty_rel", 32'(gnt), 0);
        tick();
        check("to_empty_neop", eop_q.size(), 1);
        check("to_empty_bank", 32'(dut.bank), 1);
        check("to_empty_pend", 32'(dut.pend), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
